// File: rtl/cobra_hex_display.sv
// Eight-digit multiplexed seven-segment driver showing a 32-bit word in hex.
// The displayed value is latched only at frame boundaries so a scan never
// mixes digits from two different values. Optional leading-zero blanking.
module cobra_hex_display #(
    parameter int unsigned DIV      = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        en_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a} glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [DIV_W-1:0] div_r;
    logic [2:0]       dig_r;
    logic [31:0]      shadow_r;
    logic             first_r;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_r;

    logic             div_last_s;
    logic             boundary_s;
    logic             capture_s;
    logic [31:0]      disp_val_s;
    logic [31:0]      upper_s;
    logic             blank_s;
    logic [7:0]       an_next_s;
    logic [6:0]       seg_next_s;

    // Scan timing decode, capture decision and the digit/glyph/blank selection.
    // On the very first edge after reset the value being captured is shown
    // directly, so frame 0 is drawn from a single value just like later frames.
    always_comb begin
        div_last_s = (div_r == DIV_LAST);
        boundary_s = div_last_s && (dig_r == 3'd7);
        capture_s  = (boundary_s || first_r) && en_i;
        if (first_r && en_i) begin
            disp_val_s = data_i;
        end else begin
            disp_val_s = shadow_r;
        end
        upper_s = disp_val_s >> {dig_r, 2'b00};
        if (BLANK_LZ && (dig_r != 3'd0) && (upper_s == 32'd0)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            an_next_s  = 8'hFF;
            seg_next_s = 7'h7F;
        end else begin
            an_next_s  = ~(8'd1 << dig_r);
            seg_next_s = hex_glyph(upper_s[3:0]);
        end
    end

    // Divider, digit index, shadow capture and registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r    <= '0;
            dig_r    <= 3'd0;
            shadow_r <= 32'd0;
            first_r  <= 1'b1;
            an_r     <= 8'hFF;
            seg_r    <= 7'h7F;
            dp_r     <= 1'b1;
            frame_r  <= 1'b0;
        end else begin
            if (div_last_s) begin
                div_r <= '0;
                dig_r <= dig_r + 3'd1;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (capture_s) begin
                shadow_r <= data_i;
            end
            first_r <= 1'b0;
            an_r    <= an_next_s;
            seg_r   <= seg_next_s;
            dp_r    <= 1'b1;
            frame_r <= boundary_s;
        end
    end

    assign an_o    = an_r;
    assign seg_o   = seg_r;
    assign dp_o    = dp_r;
    assign frame_o = frame_r;

endmodule

// File: tb/tb_cobra_hex_display.sv
// Randomized bench for cobra_hex_display: three instances with different
// DIV/BLANK_LZ settings share the stimulus and are checked every cycle
// against a frame-level reference model.
module tb_cobra_hex_display;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        en;

    logic [7:0]  an_w    [3];
    logic [6:0]  seg_w   [3];
    logic        dp_w    [3];
    logic        frame_w [3];

    int unsigned n_cmp;
    int unsigned n_bad;

    // Model state per instance
    int          div_p [3] = '{4, 4, 2};
    bit          blk_p [3] = '{1'b1, 1'b0, 1'b1};
    int          t_m   [3];
    logic [31:0] cur_m [3];
    logic [31:0] nxt_m [3];

    logic [6:0] glyph_m [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    cobra_hex_display #(.DIV(4), .BLANK_LZ(1'b1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
        .an_o(an_w[0]), .seg_o(seg_w[0]), .dp_o(dp_w[0]), .frame_o(frame_w[0]));
    cobra_hex_display #(.DIV(4), .BLANK_LZ(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
        .an_o(an_w[1]), .seg_o(seg_w[1]), .dp_o(dp_w[1]), .frame_o(frame_w[1]));
    cobra_hex_display #(.DIV(2), .BLANK_LZ(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
        .an_o(an_w[2]), .seg_o(seg_w[2]), .dp_o(dp_w[2]), .frame_o(frame_w[2]));

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Advance one clock, update the model with the inputs present at that edge,
    // and compare every instance.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            int          fl;
            int          k;
            logic [7:0]  an_e;
            logic [6:0]  seg_e;
            logic        fr_e;
            logic [31:0] hi;
            fl = 8 * div_p[i];
            if (rst) begin
                t_m[i] = -1;
                an_e   = 8'hFF;
                seg_e  = 7'h7F;
                fr_e   = 1'b0;
            end else begin
                if (t_m[i] < 0) begin
                    t_m[i]   = 0;
                    cur_m[i] = en ? data : 32'd0;
                end else begin
                    t_m[i] = t_m[i] + 1;
                    if (t_m[i] % fl == 0) cur_m[i] = nxt_m[i];
                end
                k  = (t_m[i] / div_p[i]) % 8;
                hi = cur_m[i] >> (4 * k);
                if (blk_p[i] && k != 0 && hi == 32'd0) begin
                    an_e  = 8'hFF;
                    seg_e = 7'h7F;
                end else begin
                    an_e  = ~(8'd1 << k);
                    seg_e = glyph_m[hi[3:0]];
                end
                fr_e = (t_m[i] % fl == fl - 1);
                if (fr_e) nxt_m[i] = en ? data : cur_m[i];
            end
            check_eq($sformatf("an%0d", i),    {24'd0, an_w[i]},    {24'd0, an_e});
            check_eq($sformatf("seg%0d", i),   {25'd0, seg_w[i]},   {25'd0, seg_e});
            check_eq($sformatf("dp%0d", i),    {31'd0, dp_w[i]},    32'd1);
            check_eq($sformatf("frame%0d", i), {31'd0, frame_w[i]}, {31'd0, fr_e});
        end
    endtask

    task automatic run(input int n, input logic [31:0] d, input logic e);
        data = d;
        en   = e;
        rst  = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [7:0]  keep;
        w    = $urandom;
        keep = 8'($urandom);
        for (int n = 0; n < 8; n++) begin
            if (!keep[n]) w[4*n +: 4] = 4'h0;
        end
        if ($urandom_range(0, 3) == 0) w = w >> (4 * $urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            t_m[i]   = -1;
            cur_m[i] = 32'd0;
            nxt_m[i] = 32'd0;
        end
        // Reset and first capture
        rst  = 1'b1;
        data = 32'h90;
        en   = 1'b1;
        for (int c = 0; c < 3; c++) step();
        run(40, 32'h90, 1'b1);
        // Full scan
        run(70, 32'h89ABCDEF, 1'b1);
        // Tear-free update: change in the middle of a frame
        run(30, 32'h11111111, 1'b1);
        run(50, 32'h12345678, 1'b1);
        // Capture disabled
        run(70, 32'hDEADBEEF, 1'b0);
        // Mid-frame reset
        run(21, 32'h0BADF00D, 1'b1);
        rst = 1'b1;
        step();
        run(40, 32'h0BADF00D, 1'b1);
        // Blanking edges
        run(40, 32'h0, 1'b1);
        run(40, 32'h10000000, 1'b1);
        run(40, 32'h00010000, 1'b1);
        // Randomized operation
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) data = rand_word();
            en  = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 120) == 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
